// File: rtl/dice_roller_multi.sv
// Multi-die roller: rolls 1..MAX_DICE dice of one type per request using a free-running
// Galois LFSR with rejection sampling, reporting each die, the running sum and a done pulse.
module dice_roller_multi #(
  parameter int unsigned                  LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0]        SEED       = LFSR_WIDTH'(16'hACE1),
  parameter int unsigned                  MAX_DICE   = 4,
  parameter int unsigned                  OUT_WIDTH  = 8,
  parameter int unsigned                  CNT_W      = $clog2(MAX_DICE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            die_select,
  input  logic [CNT_W-1:0]      num_dice,
  input  logic                  roll,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_WIDTH-1:0]  rolled_number,
  output logic [OUT_WIDTH-1:0]  roll_sum,
  output logic [CNT_W-1:0]      die_count
);

  typedef enum logic [1:0] {StIdle, StRoll, StDone} state_e;

  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
  localparam logic [LFSR_WIDTH-1:0] Taps = LFSR_WIDTH'(16'hB400);
  localparam int unsigned           SumW = OUT_WIDTH + 1;

  state_e                state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [1:0]            type_q, type_d;
  logic [CNT_W-1:0]      target_q, target_d;
  logic [OUT_WIDTH-1:0]  rolled_q, rolled_d;
  logic [OUT_WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [4:0]            raw;
  logic [4:0]            die_val;
  logic                  accept;
  logic [CNT_W-1:0]      target_in;
  logic [CNT_W-1:0]      count_inc;
  logic [SumW-1:0]       sum_ext;
  logic [OUT_WIDTH-1:0]  sum_sat;

  assign raw       = lfsr_q[4:0];
  assign count_inc = count_q + CNT_W'(1);
  assign sum_ext   = {1'b0, sum_q} + SumW'(die_val);
  assign sum_sat   = sum_ext[OUT_WIDTH] ? '1 : sum_ext[OUT_WIDTH-1:0];

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? Taps : '0);
    if (seed_load) begin
      lfsr_d = (seed_value == '0) ? SEED : seed_value;
    end
  end

  always_comb begin
    accept  = 1'b1;
    die_val = '0;
    unique case (type_q)
      2'b00: die_val = {3'b000, raw[1:0]} + 5'd1;
      2'b01: begin
        accept  = (raw[2:0] < 3'd6);
        die_val = {2'b00, raw[2:0]} + 5'd1;
      end
      2'b10: die_val = {2'b00, raw[2:0]} + 5'd1;
      default: begin
        accept  = (raw < 5'd20);
        die_val = raw + 5'd1;
      end
    endcase
  end

  always_comb begin
    if (num_dice == '0) begin
      target_in = CNT_W'(1);
    end else if (num_dice > CNT_W'(MAX_DICE)) begin
      target_in = CNT_W'(MAX_DICE);
    end else begin
      target_in = num_dice;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (roll) state_d = StRoll;
      StRoll:  if (accept && (count_inc == target_q)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    type_d   = type_q;
    target_d = target_q;
    rolled_d = rolled_q;
    sum_d    = sum_q;
    count_d  = count_q;
    if ((state_q == StIdle) && roll) begin
      type_d   = die_select;
      target_d = target_in;
      sum_d    = '0;
      count_d  = '0;
    end else if ((state_q == StRoll) && accept) begin
      rolled_d = OUT_WIDTH'(die_val);
      sum_d    = sum_sat;
      count_d  = count_inc;
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    rolled_number = rolled_q;
    roll_sum      = sum_q;
    die_count     = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      lfsr_q   <= SEED;
      type_q   <= 2'b00;
      target_q <= CNT_W'(1);
      rolled_q <= '0;
      sum_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      type_q   <= type_d;
      target_q <= target_d;
      rolled_q <= rolled_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_dice_roller_multi.sv
// Directed bench for dice_roller_multi: table of seeded requests with hand-computed LFSR
// outcomes, plus sequences for reset, rejection, mid-roll reset and zero seed.
module tb_dice_roller_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  die_select;
  logic [2:0]  num_dice;
  logic        roll;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        busy;
  logic        done;
  logic [7:0]  rolled_number;
  logic [7:0]  roll_sum;
  logic [2:0]  die_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dice_roller_multi #(
    .LFSR_WIDTH(16),
    .SEED(16'hACE1),
    .MAX_DICE(4),
    .OUT_WIDTH(8),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .die_select(die_select),
    .num_dice(num_dice),
    .roll(roll),
    .seed_load(seed_load),
    .seed_value(seed_value),
    .busy(busy),
    .done(done),
    .rolled_number(rolled_number),
    .roll_sum(roll_sum),
    .die_count(die_count)
  );

  typedef struct {
    logic [1:0]  die;
    logic [2:0]  num;
    logic [15:0] seed;
    int          exp_last;
    int          exp_sum;
    int          exp_count;
    int          exp_edges;
  } row_t;

  row_t rows[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Seed is loaded in the accept cycle, so the first sample is the seed itself.
  // roll is held high (with scrambled selects) through the whole busy period.
  task automatic run_row(input row_t r, input int idx);
    int cyc;
    @(negedge clk);
    die_select = r.die;
    num_dice   = r.num;
    seed_value = r.seed;
    seed_load  = 1'b1;
    roll       = 1'b1;
    @(negedge clk);
    seed_load  = 1'b0;
    seed_value = '0;
    die_select = ~r.die;
    num_dice   = 3'd1;
    check($sformatf("row%0d busy", idx), int'(busy), 1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("row%0d latency", idx), cyc, r.exp_edges);
    check($sformatf("row%0d last", idx), int'(rolled_number), r.exp_last);
    check($sformatf("row%0d sum", idx), int'(roll_sum), r.exp_sum);
    check($sformatf("row%0d count", idx), int'(die_count), r.exp_count);
    @(negedge clk);
    roll = 1'b0;
    check($sformatf("row%0d done_pulse", idx), int'(done), 0);
    check($sformatf("row%0d idle", idx), int'(busy), 0);
    @(negedge clk);
    check($sformatf("row%0d no_requeue", idx), int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rows[0] = '{2'd0, 3'd1, 16'h0001,  2,  2, 1, 1};
    rows[1] = '{2'd3, 3'd4, 16'hBEEF,  7, 52, 4, 9};
    rows[2] = '{2'd1, 3'd3, 16'h0007,  1,  7, 3, 4};
    rows[3] = '{2'd2, 3'd0, 16'h0005,  6,  6, 1, 1};
    rows[4] = '{2'd2, 3'd7, 16'h0001,  1,  5, 4, 4};
    rows[5] = '{2'd0, 3'd4, 16'h0007,  1, 11, 4, 4};
    rows[6] = '{2'd1, 3'd2, 16'h0006,  2,  6, 2, 3};

    reset      = 1'b1;
    roll       = 1'b0;
    seed_load  = 1'b0;
    seed_value = '0;
    die_select = 2'd0;
    num_dice   = 3'd0;
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset rolled", int'(rolled_number), 0);
    check("reset sum", int'(roll_sum), 0);
    check("reset count", int'(die_count), 0);

    // First sample after reset is ACE1 stepped once = E270 -> d20 face 17
    reset      = 1'b0;
    roll       = 1'b1;
    die_select = 2'd3;
    num_dice   = 3'd1;
    @(negedge clk);
    roll = 1'b0;
    check("seed busy", int'(busy), 1);
    @(negedge clk);
    check("seed done", int'(done), 1);
    check("seed rolled", int'(rolled_number), 17);
    check("seed sum", int'(roll_sum), 17);
    @(negedge clk);
    check("seed done_pulse", int'(done), 0);

    // d6 with seed 0007: first sample rejected, then 4, 2, 1
    seed_value = 16'h0007;
    seed_load  = 1'b1;
    roll       = 1'b1;
    die_select = 2'd1;
    num_dice   = 3'd3;
    @(negedge clk);
    seed_load = 1'b0;
    roll      = 1'b0;
    @(negedge clk);
    check("reject rolled_hold", int'(rolled_number), 17);
    check("reject sum", int'(roll_sum), 0);
    check("reject count", int'(die_count), 0);
    check("reject busy", int'(busy), 1);
    check("reject done", int'(done), 0);
    @(negedge clk);
    check("d6 first", int'(rolled_number), 4);
    check("d6 first count", int'(die_count), 1);
    @(negedge clk);
    check("d6 second", int'(rolled_number), 2);
    check("d6 second sum", int'(roll_sum), 6);
    @(negedge clk);
    check("d6 third", int'(rolled_number), 1);
    check("d6 total", int'(roll_sum), 7);
    check("d6 done", int'(done), 1);

    for (int i = 0; i < 7; i++) begin
      run_row(rows[i], i);
    end

    // Reset during the second ROLL cycle of a d20 x4 request
    @(negedge clk);
    seed_value = 16'hBEEF;
    seed_load  = 1'b1;
    roll       = 1'b1;
    die_select = 2'd3;
    num_dice   = 3'd4;
    @(negedge clk);
    seed_load = 1'b0;
    roll      = 1'b0;
    @(negedge clk);
    check("abort pre rolled", int'(rolled_number), 16);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort rolled", int'(rolled_number), 0);
    check("abort sum", int'(roll_sum), 0);
    check("abort count", int'(die_count), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort no_done%0d", i), int'(done), 0);
    end

    // Zero seed falls back to ACE1, whose low bits give d20 face 2
    seed_value = 16'h0000;
    seed_load  = 1'b1;
    roll       = 1'b1;
    die_select = 2'd3;
    num_dice   = 3'd1;
    @(negedge clk);
    seed_load = 1'b0;
    roll      = 1'b0;
    @(negedge clk);
    check("zero seed done", int'(done), 1);
    check("zero seed rolled", int'(rolled_number), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
